id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline stage directly upstream of the ALU. It registers one decoded instruction per
//   valid/ready handshake and decodes aluop/funct into the 4-bit ALU control code. It applies
//   EX/MEM and MEM/WB forwarding and drives the ALU's A, B and ALUctr inputs.
// PARAMETERS
//   DATA_W  32  datapath width (ALU operands, immediates, forwarded results)
//   REG_AW  5   register-address width
// PORTS
//   clk            in   1       rising-edge clock
//   rst_n          in   1       asynchronous active-low reset
//   in_valid       in   1       decode stage presents an instruction
//   in_ready       out  1       stage can accept this cycle
//   flush          in   1       squash held and incoming instruction (branch/jump redirect)
//   in_rs_addr     in   REG_AW  rs index
//   in_rt_addr     in   REG_AW  rt index
//   in_rd_addr     in   REG_AW  destination index (already rd/rt selected)
//   in_rs_data     in   DATA_W  regfile rs value
//   in_rt_data     in   DATA_W  regfile rt value
//   in_imm         in   DATA_W  extended immediate
//   in_alusrc      in   1       1: B = imm, 0: B = rt
//   in_aluop       in   2       00 add, 01 sub, 10 R-type (use funct), 11 or-immediate
//   in_funct       in   6       instr[5:0]
//   in_regwrite    in   1       writeback enable
//   in_memread     in   1       load
//   in_memwrite    in   1       store
//   exmem_regwrite in   1       EX/MEM writes a register
//   exmem_rd       in   REG_AW  EX/MEM destination
//   exmem_result   in   DATA_W  EX/MEM ALU result
//   memwb_regwrite in   1       MEM/WB writes a register
//   memwb_rd       in   REG_AW  MEM/WB destination
//   memwb_result   in   DATA_W  MEM/WB writeback value
//   out_valid      out  1       held instruction valid toward ALU/EX-MEM
//   out_ready      in   1       downstream accepts this cycle
//   alu_a          out  DATA_W  ALU operand A (forwarded rs)
//   alu_b          out  DATA_W  ALU operand B (imm or forwarded rt)
//   alu_ctr        out  4       ALU control code
//   store_data     out  DATA_W  forwarded rt for stores
//   out_rd_addr    out  REG_AW  registered destination
//   out_regwrite / out_memread / out_memwrite  out 1  registered controls, forced 0 when !out_valid
//   out_illegal    out  1       R-type funct not in the supported set
// BEHAVIOUR
//   - Reset (async, rst_n=0): out_valid=0, every held field=0; alu_ctr=4'b0000, outputs follow.
//   - in_ready = !out_valid | out_ready (combinational; no dependence on in_valid).
//   - load = in_valid & in_ready & !flush. On load, all in_* fields are captured. Latency is
//     1 cycle (captured at edge N, presented from N+1).
//   - out_valid next: flush->0; else load->1; else out_ready->0; else hold. Flush dominates load.
//   - Held fields do not change while out_valid=1 and out_ready=0 (stall), except the
//     combinational forwarding outputs, which track the exmem_*/memwb_* inputs.
//   - ALU control decode is registered at load time:
//     aluop 00->1000 (add), 01->0110 (sub), 11->0001 (or);
//     aluop 10 with funct: 100000->1000, 100010->0110, 100100->0000, 100101->0001,
//     100111->1100, 101010->0111; other funct->1000 with out_illegal=1.
//   - Forwarding, per operand X in {rs, rt} with held index rX:
//     if exmem_regwrite & exmem_rd==rX & rX!=0 -> exmem_result;
//     elif memwb_regwrite & memwb_rd==rX & rX!=0 -> memwb_result; else held regfile value.
//     EX/MEM has priority. Register 0 is never forwarded.
//   - alu_a = fwd_rs; alu_b = alusrc ? imm : fwd_rt; store_data = fwd_rt (always).
//   - Load-use hazard detection belongs to the decode stage, not this block.
//   - Back-to-back transfers: out_valid=1, out_ready=1 and in_valid=1 move one instruction per
//     cycle with no bubble.
// STRUCTURE
//   - Shared package mips_pkg: ALUCTR_AND/OR/ADD/SUB/SLT/NOR constants, ALUOP_* encodings,
//     FUNCT_* codes.
//   - Sub-module fwd_mux (combinational): one instance per operand (rs, rt); it takes the held
//     index/data plus the exmem/memwb ports and returns the forwarded value.
//   - The decode, pipeline register and valid FSM live in id_ex_stage.
// TESTING
//   1. rst_n=0 mid-stall with out_valid=1 -> out_valid=0 and alu_ctr=0000 immediately;
//      in_ready=1 after release.
//   2. Load aluop=10, funct=100111, rs=5, rt=6, no forwarding -> next cycle alu_ctr=1100,
//      alu_a=rs_data, alu_b=rt_data.
//   3. rs=rt=3; exmem_rd=3 with exmem_result=0xAAAA; memwb_rd=3 with memwb_result=0xBBBB,
//      both writing -> alu_a=0xAAAA. Drop exmem_regwrite -> alu_a=0xBBBB.
//   4. rs=0 with exmem_rd=0 and exmem_regwrite=1 -> alu_a=in_rs_data, not exmem_result.
//   5. out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and the held fields are unchanged.
//      Then out_ready=1 -> the new instruction loads with no lost or duplicated transfer.
//   6. flush together with in_valid=1 and in_ready=1 -> next cycle out_valid=0 and
//      out_regwrite=0. Also funct=111111 with aluop=10 -> out_illegal=1, alu_ctr=1000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared ALU control codes, ALU-op encodings, R-type funct codes and the ALU control decode.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package mips_pkg;

  localparam logic [3:0] ALUCTR_AND = 4'b0000;
  localparam logic [3:0] ALUCTR_OR  = 4'b0001;
  localparam logic [3:0] ALUCTR_ADD = 4'b1000;
  localparam logic [3:0] ALUCTR_SUB = 4'b0110;
  localparam logic [3:0] ALUCTR_SLT = 4'b0111;
  localparam logic [3:0] ALUCTR_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Registered ALU control plus the unsupported-funct flag.
  typedef struct packed {
    logic       illegal;
    logic [3:0] ctr;
  } aluctl_t;

  // Control bits carried through the stage alongside the operands.
  typedef struct packed {
    logic alusrc;
    logic regwrite;
    logic memread;
    logic memwrite;
  } ctrl_t;

  // Unsupported R-type functs fall back to add so the ALU still does something benign.
  function automatic aluctl_t alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    aluctl_t d;
    d.illegal = 1'b0;
    d.ctr     = ALUCTR_ADD;
    case (aluop)
      ALUOP_ADD: d.ctr = ALUCTR_ADD;
      ALUOP_SUB: d.ctr = ALUCTR_SUB;
      ALUOP_ORI: d.ctr = ALUCTR_OR;
      default: begin
        case (funct)
          FUNCT_ADD: d.ctr = ALUCTR_ADD;
          FUNCT_SUB: d.ctr = ALUCTR_SUB;
          FUNCT_AND: d.ctr = ALUCTR_AND;
          FUNCT_OR:  d.ctr = ALUCTR_OR;
          FUNCT_NOR: d.ctr = ALUCTR_NOR;
          FUNCT_SLT: d.ctr = ALUCTR_SLT;
          default: begin
            d.ctr     = ALUCTR_ADD;
            d.illegal = 1'b1;
          end
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decode-side handshake and fields, forwarding sources, ALU-side outputs.
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready valid-ready pairs on the decode and ALU sides.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  import mips_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [REG_AW-1:0] in_rs_addr;
  logic [REG_AW-1:0] in_rt_addr;
  logic [REG_AW-1:0] in_rd_addr;
  logic [DATA_W-1:0] in_rs_data;
  logic [DATA_W-1:0] in_rt_data;
  logic [DATA_W-1:0] in_imm;
  logic              in_alusrc;
  logic [1:0]        in_aluop;
  logic [5:0]        in_funct;
  logic              in_regwrite;
  logic              in_memread;
  logic              in_memwrite;

  logic              exmem_regwrite;
  logic [REG_AW-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_regwrite;
  logic [REG_AW-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_result;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_ctr;
  logic [DATA_W-1:0] store_data;
  logic [REG_AW-1:0] out_rd_addr;
  logic              out_regwrite;
  logic              out_memread;
  logic              out_memwrite;
  logic              out_illegal;

  // Stage view.
  modport slave (
    input  in_valid, flush, in_rs_addr, in_rt_addr, in_rd_addr, in_rs_data, in_rt_data,
           in_imm, in_alusrc, in_aluop, in_funct, in_regwrite, in_memread, in_memwrite,
           exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
           out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_ctr, store_data, out_rd_addr,
           out_regwrite, out_memread, out_memwrite, out_illegal
  );

  // Surrounding pipeline view.
  modport master (
    output in_valid, flush, in_rs_addr, in_rt_addr, in_rd_addr, in_rs_data, in_rt_data,
           in_imm, in_alusrc, in_aluop, in_funct, in_regwrite, in_memread, in_memwrite,
           exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
           out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_ctr, store_data, out_rd_addr,
           out_regwrite, out_memread, out_memwrite, out_illegal
  );
endinterface

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM result, else MEM/WB result, else the held regfile value.
// Latency: combinational.
// Backpressure: none; output tracks its inputs every cycle.
module fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rx,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] fwd
);

  // The younger EX/MEM producer wins; $zero is hardwired so it is never forwarded.
  always_comb begin
    fwd = rx_data;
    if (exmem_regwrite && (exmem_rd == rx) && (rx != '0))
      fwd = exmem_result;
    else if (memwb_regwrite && (memwb_rd == rx) && (rx != '0))
      fwd = memwb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register ahead of the ALU: captures decoded instruction, decodes ALU control, forwards.
// Latency: 1 cycle from accepted input to presented output; forwarding muxes are combinational.
// Backpressure: in_ready = !out_valid | out_ready, so a stalled ALU side holds the stage full.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic        clk,
  input logic        rst_n,
  id_ex_stage_if.slave bus
);

  logic              load;
  logic              valid_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  ctrl_t             ctrl_q;
  aluctl_t           aluctl_q;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  assign bus.in_ready = !valid_q | bus.out_ready;
  assign load         = bus.in_valid & bus.in_ready & ~bus.flush;

  // Valid bit: flush squashes everything, a load refills, a downstream accept drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      valid_q <= 1'b0;
    else if (bus.flush)
      valid_q <= 1'b0;
    else if (load)
      valid_q <= 1'b1;
    else if (bus.out_ready)
      valid_q <= 1'b0;
  end

  // Payload only moves on a load, so it is frozen for the whole of a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
      aluctl_q  <= '0;
    end else if (load) begin
      rs_q      <= bus.in_rs_addr;
      rt_q      <= bus.in_rt_addr;
      rd_q      <= bus.in_rd_addr;
      rs_data_q <= bus.in_rs_data;
      rt_data_q <= bus.in_rt_data;
      imm_q     <= bus.in_imm;
      ctrl_q    <= '{alusrc:   bus.in_alusrc,
                     regwrite: bus.in_regwrite,
                     memread:  bus.in_memread,
                     memwrite: bus.in_memwrite};
      aluctl_q  <= alu_decode(bus.in_aluop, bus.in_funct);
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .rx             (rs_q),
    .rx_data        (rs_data_q),
    .exmem_regwrite (bus.exmem_regwrite),
    .exmem_rd       (bus.exmem_rd),
    .exmem_result   (bus.exmem_result),
    .memwb_regwrite (bus.memwb_regwrite),
    .memwb_rd       (bus.memwb_rd),
    .memwb_result   (bus.memwb_result),
    .fwd            (fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .rx             (rt_q),
    .rx_data        (rt_data_q),
    .exmem_regwrite (bus.exmem_regwrite),
    .exmem_rd       (bus.exmem_rd),
    .exmem_result   (bus.exmem_result),
    .memwb_regwrite (bus.memwb_regwrite),
    .memwb_rd       (bus.memwb_rd),
    .memwb_result   (bus.memwb_result),
    .fwd            (fwd_rt)
  );

  assign bus.out_valid    = valid_q;
  assign bus.alu_a        = fwd_rs;
  assign bus.alu_b        = ctrl_q.alusrc ? imm_q : fwd_rt;
  assign bus.store_data   = fwd_rt;
  assign bus.alu_ctr      = aluctl_q.ctr;
  assign bus.out_illegal  = aluctl_q.illegal;
  assign bus.out_rd_addr  = rd_q;
  // Side-effecting controls are gated so an empty stage can never write or access memory.
  assign bus.out_regwrite = valid_q & ctrl_q.regwrite;
  assign bus.out_memread  = valid_q & ctrl_q.memread;
  assign bus.out_memwrite = valid_q & ctrl_q.memwrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed steps plus a randomized handshake run.
// Latency: expects 1-cycle capture-to-present.
// Backpressure: drives out_ready stalls and flushes; scoreboard tracks every transfer.
module tb_id_ex_stage;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic        alusrc;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [3:0]  ctr;
    logic        ill;
  } ent_t;

  ent_t q[$];
  ent_t pend;
  logic m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (bus.exmem_regwrite && bus.exmem_rd == a && a != 5'd0) return bus.exmem_result;
    if (bus.memwb_regwrite && bus.memwb_rd == a && a != 5'd0) return bus.memwb_result;
    return d;
  endfunction

  function automatic ent_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] rsd, input logic [31:0] rtd,
                              input logic [31:0] imm, input logic alusrc,
                              input logic [3:0] ctr, input logic ill);
    ent_t e;
    e.rs = rs; e.rt = rt; e.rd = rd; e.rsd = rsd; e.rtd = rtd; e.imm = imm;
    e.alusrc = alusrc; e.rw = 1'b1; e.mr = 1'b0; e.mw = 1'b0; e.ctr = ctr; e.ill = ill;
    return e;
  endfunction

  task automatic set_in(input logic v, input ent_t e, input logic [1:0] op, input logic [5:0] fn);
    bus.in_valid    = v;
    bus.in_rs_addr  = e.rs;
    bus.in_rt_addr  = e.rt;
    bus.in_rd_addr  = e.rd;
    bus.in_rs_data  = e.rsd;
    bus.in_rt_data  = e.rtd;
    bus.in_imm      = e.imm;
    bus.in_alusrc   = e.alusrc;
    bus.in_regwrite = e.rw;
    bus.in_memread  = e.mr;
    bus.in_memwrite = e.mw;
    bus.in_aluop    = op;
    bus.in_funct    = fn;
    pend = e;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.exmem_regwrite = ew; bus.exmem_rd = erd; bus.exmem_result = eres;
    bus.memwb_regwrite = mw; bus.memwb_rd = mrd; bus.memwb_result = mres;
  endtask

  // One clock: check at the falling edge against the scoreboard, then advance the model.
  task automatic cycle();
    logic exp_rdy;
    logic ld;
    ent_t e;
    @(negedge clk);
    exp_rdy = !m_valid | bus.out_ready;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q[0];
        chk("alu_a", bus.alu_a, fwd(e.rs, e.rsd));
        chk("alu_b", bus.alu_b, e.alusrc ? e.imm : fwd(e.rt, e.rtd));
        chk("store_data", bus.store_data, fwd(e.rt, e.rtd));
        chk("alu_ctr", 32'(bus.alu_ctr), 32'(e.ctr));
        chk("out_illegal", 32'(bus.out_illegal), 32'(e.ill));
        chk("out_rd_addr", 32'(bus.out_rd_addr), 32'(e.rd));
        chk("out_regwrite", 32'(bus.out_regwrite), 32'(e.rw));
        chk("out_memread", 32'(bus.out_memread), 32'(e.mr));
        chk("out_memwrite", 32'(bus.out_memwrite), 32'(e.mw));
        if (bus.out_ready || bus.flush) void'(q.pop_front());
      end
    end else begin
      chk("idle_regwrite", 32'(bus.out_regwrite), 32'd0);
      chk("idle_memread", 32'(bus.out_memread), 32'd0);
      chk("idle_memwrite", 32'(bus.out_memwrite), 32'd0);
    end
    ld = bus.in_valid & exp_rdy & !bus.flush;
    if (ld) q.push_back(pend);
    if (bus.flush) m_valid = 1'b0;
    else if (ld) m_valid = 1'b1;
    else if (bus.out_ready) m_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pick(input int k, output logic [1:0] op, output logic [5:0] fn,
                      output logic [3:0] ctr, output logic ill);
    ill = 1'b0;
    case (k)
      0: begin op = 2'b00; fn = 6'b000000; ctr = 4'b1000; end
      1: begin op = 2'b01; fn = 6'b100101; ctr = 4'b0110; end
      2: begin op = 2'b11; fn = 6'b100010; ctr = 4'b0001; end
      3: begin op = 2'b10; fn = 6'b100000; ctr = 4'b1000; end
      4: begin op = 2'b10; fn = 6'b100010; ctr = 4'b0110; end
      5: begin op = 2'b10; fn = 6'b100100; ctr = 4'b0000; end
      6: begin op = 2'b10; fn = 6'b100101; ctr = 4'b0001; end
      7: begin op = 2'b10; fn = 6'b100111; ctr = 4'b1100; end
      8: begin op = 2'b10; fn = 6'b101010; ctr = 4'b0111; end
      default: begin op = 2'b10; fn = 6'b000011; ctr = 4'b1000; ill = 1'b1; end
    endcase
  endtask

  initial begin
    ent_t e;
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] ctr;
    logic ill;
    n_chk = 0;
    n_fail = 0;
    m_valid = 1'b0;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    set_in(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0), 2'b00, 6'd0);
    set_fwd(0, 0, 0, 0, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu_ctr", 32'(bus.alu_ctr), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    cycle();

    // NOR R-type, no forwarding.
    set_in(1'b1, mk(5, 6, 7, 32'h1111_0005, 32'h2222_0006, 32'h0000_00ff, 0, 4'b1100, 0),
           2'b10, 6'b100111);
    cycle();
    bus.in_valid = 1'b0;
    chk("nor_alu_ctr", 32'(bus.alu_ctr), 32'h0000_000c);
    chk("nor_alu_a", bus.alu_a, 32'h1111_0005);
    chk("nor_alu_b", bus.alu_b, 32'h2222_0006);
    cycle();

    // EX/MEM beats MEM/WB; then MEM/WB alone.
    set_fwd(1, 3, 32'h0000_aaaa, 1, 3, 32'h0000_bbbb);
    set_in(1'b1, mk(3, 3, 9, 32'h33, 32'h333, 32'h0, 0, 4'b1000, 0), 2'b00, 6'd0);
    cycle();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("fwd_exmem_a", bus.alu_a, 32'h0000_aaaa);
    cycle();
    bus.exmem_regwrite = 1'b0;
    #1;
    chk("fwd_memwb_a", bus.alu_a, 32'h0000_bbbb);
    chk("fwd_memwb_store", bus.store_data, 32'h0000_bbbb);
    bus.out_ready = 1'b1;
    cycle();

    // Register 0 is never forwarded.
    set_fwd(1, 0, 32'h0000_dead, 1, 0, 32'h0000_beef);
    set_in(1'b1, mk(0, 0, 4, 32'h1234, 32'h5678, 32'h0000_0010, 1, 4'b0001, 0), 2'b11, 6'd0);
    cycle();
    bus.in_valid = 1'b0;
    chk("r0_alu_a", bus.alu_a, 32'h1234);
    chk("r0_alu_b_imm", bus.alu_b, 32'h0000_0010);
    cycle();
    set_fwd(0, 0, 0, 0, 0, 0);

    // Three-cycle stall with a waiting instruction, then release.
    set_in(1'b1, mk(1, 2, 10, 32'ha1, 32'ha2, 32'h0, 0, 4'b0110, 0), 2'b01, 6'd0);
    cycle();
    set_in(1'b1, mk(2, 1, 11, 32'hb1, 32'hb2, 32'h0, 0, 4'b0111, 0), 2'b10, 6'b101010);
    bus.out_ready = 1'b0;
    repeat (3) cycle();
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_rd_held", 32'(bus.out_rd_addr), 32'd10);
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    cycle();

    // Reset mid-stall.
    set_in(1'b1, mk(4, 5, 12, 32'hc1, 32'hc2, 32'h0, 0, 4'b0000, 0), 2'b10, 6'b100100);
    cycle();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    cycle();
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_alu_ctr", 32'(bus.alu_ctr), 32'd0);
    chk("arst_regwrite", 32'(bus.out_regwrite), 32'd0);
    q.delete();
    m_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    cycle();
    bus.out_ready = 1'b1;

    // Flush dominates load; then an illegal funct.
    set_in(1'b1, mk(1, 1, 13, 32'hd1, 32'hd2, 32'h0, 0, 4'b1000, 0), 2'b00, 6'd0);
    cycle();
    set_in(1'b1, mk(2, 2, 14, 32'he1, 32'he2, 32'h0, 0, 4'b0110, 0), 2'b01, 6'd0);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_regwrite", 32'(bus.out_regwrite), 32'd0);
    cycle();
    set_in(1'b1, mk(3, 4, 15, 32'hf1, 32'hf2, 32'h0, 0, 4'b1000, 1), 2'b10, 6'b111111);
    cycle();
    bus.in_valid = 1'b0;
    chk("illegal_flag", 32'(bus.out_illegal), 32'd1);
    chk("illegal_ctr", 32'(bus.alu_ctr), 32'h0000_0008);
    cycle();

    // Randomized traffic: stalls, flushes, forwarding collisions, back-to-back transfers.
    for (int i = 0; i < 300; i++) begin
      pick(int'($urandom_range(0, 9)), op, fn, ctr, ill);
      e = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
             $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), ctr, ill);
      e.rw = 1'($urandom_range(0, 1));
      e.mr = 1'($urandom_range(0, 1));
      e.mw = 1'($urandom_range(0, 1));
      set_in(1'($urandom_range(0, 3) != 0), e, op, fn);
      set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      bus.out_ready = (i < 40) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      bus.flush = 1'($urandom_range(0, 15) == 0);
      cycle();
    end

    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
